// File: rtl/prim_cmd_list_pkg.sv
// Shared constants and state type for the primitive command-list fetcher.
package prim_cmd_list_pkg;

    localparam logic [15:0] PR_LIST_END = 16'hFFFF;

    localparam logic [3:0] PR_COORDX0 = 4'h0;
    localparam logic [3:0] PR_COORDY0 = 4'h1;
    localparam logic [3:0] PR_COORDX1 = 4'h2;
    localparam logic [3:0] PR_COORDY1 = 4'h3;
    localparam logic [3:0] PR_COORDX2 = 4'h4;
    localparam logic [3:0] PR_COORDY2 = 4'h5;
    localparam logic [3:0] PR_COLOR   = 4'h6;
    localparam logic [3:0] PR_EXECUTE = 4'h8;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StData,
        StIssue,
        StWaitStart,
        StWaitDone
    } prim_list_st_t;

endpackage

// File: rtl/prim_cmd_list.sv
// Fetches 16-bit renderer commands from VRAM and strobes them to the primitive renderer,
// stalling after each execute until the renderer has started and finished drawing.
module prim_cmd_list
    import prim_cmd_list_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 3
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] list_addr_i,
    output logic        vram_sel_o,
    output logic [15:0] vram_addr_o,
    input  logic        vram_ack_i,
    input  logic [15:0] vram_data_i,
    output logic [15:0] cmd_o,
    output logic        cmd_valid_o,
    input  logic        rndr_busy_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] count_o
);

    localparam logic [TIMEOUT_W-1:0] TmoOne = 1;

    prim_list_st_t        state_q;
    logic [15:0]          ptr_q;
    logic [15:0]          cmd_q;
    logic [15:0]          count_q;
    logic                 sel_q;
    logic                 valid_q;
    logic [TIMEOUT_W-1:0] tmo_q;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cmd_q   <= '0;
            count_q <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        ptr_q   <= list_addr_i;
                        count_q <= '0;
                        sel_q   <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (abort_i) begin
                        sel_q   <= 1'b0;
                        state_q <= StIdle;
                    end else if (vram_ack_i) begin
                        ptr_q   <= ptr_q + 16'd1;
                        sel_q   <= 1'b0;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (abort_i || vram_data_i == PR_LIST_END) begin
                        state_q <= StIdle;
                    end else begin
                        // count is bumped here so it is already current during the strobe
                        cmd_q   <= vram_data_i;
                        valid_q <= 1'b1;
                        count_q <= count_q + 16'd1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (abort_i) begin
                        state_q <= StIdle;
                    end else if (cmd_q[15:12] == PR_EXECUTE) begin
                        tmo_q   <= '1;
                        state_q <= StWaitStart;
                    end else begin
                        sel_q   <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StWaitStart: begin
                    if (abort_i) begin
                        state_q <= StIdle;
                    end else if (rndr_busy_i) begin
                        state_q <= StWaitDone;
                    end else if (tmo_q == '0) begin
                        // renderer never started: treat the execute as a no-op
                        sel_q   <= 1'b1;
                        state_q <= StReq;
                    end else begin
                        tmo_q <= tmo_q - TmoOne;
                    end
                end
                StWaitDone: begin
                    if (abort_i) begin
                        state_q <= StIdle;
                    end else if (!rndr_busy_i) begin
                        sel_q   <= 1'b1;
                        state_q <= StReq;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign vram_sel_o  = sel_q;
    assign vram_addr_o = ptr_q;
    assign cmd_o       = cmd_q;
    assign cmd_valid_o = valid_q;
    assign count_o     = count_q;
    assign busy_o      = (state_q != StIdle);
    // terminator is only known while its data is on the bus, so done must be combinational
    assign done_o      = (state_q == StData) && !abort_i && (vram_data_i == PR_LIST_END);

endmodule

// File: tb/tb_prim_cmd_list.sv
// Directed bench for prim_cmd_list with a VRAM/arbiter model, a renderer busy model and a
// list-walking reference that predicts addresses, commands, counts and busy per cycle.
module tb_prim_cmd_list;
    import prim_cmd_list_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] list_addr_i = '0;
    logic        vram_sel_o;
    logic [15:0] vram_addr_o;
    logic        vram_ack_i = 1'b0;
    logic [15:0] vram_data_i = '0;
    logic [15:0] cmd_o;
    logic        cmd_valid_o;
    logic        rndr_busy_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [15:0] count_o;

    always #5 clk = ~clk;

    prim_cmd_list #(.TIMEOUT_W(3)) dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .list_addr_i (list_addr_i),
        .vram_sel_o  (vram_sel_o),
        .vram_addr_o (vram_addr_o),
        .vram_ack_i  (vram_ack_i),
        .vram_data_i (vram_data_i),
        .cmd_o       (cmd_o),
        .cmd_valid_o (cmd_valid_o),
        .rndr_busy_i (rndr_busy_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .count_o     (count_o)
    );

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;

    // environment knobs
    int ack_delay = 0;
    bit ack_en    = 1'b1;
    bit rndr_resp = 1'b1;
    int busy_len  = 40;
    int busy_start = -100;
    int busy_end   = -100;
    int stall_cnt  = 0;

    // reference model state
    bit          model_busy = 1'b0;
    bit          done_prev  = 1'b0;
    logic [15:0] exp_addrs[$];
    logic [15:0] exp_cmds[$];
    int          exp_n = 0;
    int          issued = 0;

    // observation logs
    int          strobe_cyc[$];
    int          sel_rise[$];
    logic [15:0] hs_addr[$];
    logic [15:0] cmd_log[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    bit          prev_sel = 1'b0;
    bit          prev_ack = 1'b0;
    logic [15:0] prev_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
    endtask

    // Walk the list in memory the way the renderer contract describes it.
    task automatic build_expect(input logic [15:0] a);
        logic [15:0] p;
        p = a;
        exp_addrs.delete();
        exp_cmds.delete();
        exp_n = 0;
        for (int i = 0; i < 1000; i++) begin
            exp_addrs.push_back(p);
            if (mem[p] == PR_LIST_END) break;
            exp_cmds.push_back(mem[p]);
            exp_n++;
            p = p + 16'd1;
        end
    endtask

    function automatic int next_sel_after(input int s);
        foreach (sel_rise[i]) if (sel_rise[i] > s) return sel_rise[i];
        return -1;
    endfunction

    task automatic tick();
        bit stable_expected;
        @(negedge clk);
        cyc++;
        // inputs seen here were the ones applied during the previous cycle
        stable_expected = prev_sel && !prev_ack && !abort_i && !reset_i;
        if (reset_i) begin
            model_busy = 1'b0;
            exp_addrs.delete();
            exp_cmds.delete();
        end else if (abort_i && model_busy) begin
            model_busy = 1'b0;
            exp_addrs.delete();
            exp_cmds.delete();
        end else if (start_i && !model_busy) begin
            model_busy = 1'b1;
        end else if (done_prev) begin
            model_busy = 1'b0;
        end
        chk("busy", busy_o, model_busy);

        done_prev = done_o;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_cmds_left", exp_cmds.size(), 0);
        end

        if (cmd_valid_o) begin
            strobe_cyc.push_back(cyc);
            cmd_log.push_back(cmd_o);
            if (exp_cmds.size() == 0) fail("cmd_unexpected");
            else chk("cmd_word", cmd_o, exp_cmds.pop_front());
            issued++;
            chk("count_at_strobe", count_o, issued);
            if (cmd_o[15:12] == PR_EXECUTE && rndr_resp) begin
                busy_start = cyc + 2;
                busy_end   = cyc + 1 + busy_len;
            end
        end

        if (stable_expected) begin
            chk("sel_hold", vram_sel_o, 1);
            chk("addr_hold", vram_addr_o, prev_addr);
        end
        if (vram_sel_o && !prev_sel) sel_rise.push_back(cyc);

        vram_ack_i = 1'b0;
        if (vram_sel_o && ack_en) begin
            if (stall_cnt >= ack_delay) begin
                vram_ack_i  = 1'b1;
                vram_data_i = mem[vram_addr_o];
                stall_cnt   = 0;
                hs_addr.push_back(vram_addr_o);
                if (exp_addrs.size() == 0) fail("req_unexpected");
                else chk("req_addr", vram_addr_o, exp_addrs.pop_front());
            end else begin
                stall_cnt++;
            end
        end else if (!vram_sel_o) begin
            stall_cnt = 0;
        end
        prev_sel    = vram_sel_o;
        prev_ack    = vram_ack_i;
        prev_addr   = vram_addr_o;
        rndr_busy_i = (cyc >= busy_start) && (cyc <= busy_end);
    endtask

    task automatic start_list(input logic [15:0] a);
        build_expect(a);
        issued = 0;
        done_cnt = 0;
        strobe_cyc.delete();
        sel_rise.delete();
        hs_addr.delete();
        cmd_log.delete();
        list_addr_i = a;
        start_i = 1'b1;
        c0 = cyc;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == 0) fail({name, "_timeout"});
        tick();
        chk({name, "_count"}, count_o, exp_n);
        chk({name, "_cmds_left"}, exp_cmds.size(), 0);
        chk({name, "_addrs_left"}, exp_addrs.size(), 0);
    endtask

    task automatic check_basic_list(input string name);
        chk({name, "_strobes"}, strobe_cyc.size(), 3);
        if (cmd_log.size() == 3) begin
            chk({name, "_w0"}, cmd_log[0], 16'h000A);
            chk({name, "_w1"}, cmd_log[1], 16'h1014);
            chk({name, "_w2"}, cmd_log[2], 16'h605A);
        end
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_count_lit"}, count_o, 3);
    endtask

    int s;

    initial begin
        mem[16'h1000] = 16'h000A;
        mem[16'h1001] = 16'h1014;
        mem[16'h1002] = 16'h605A;
        mem[16'h1003] = 16'hFFFF;
        mem[16'h1004] = 16'h1234;
        mem[16'h3000] = 16'h0001;
        mem[16'h3001] = 16'h1002;
        mem[16'h3002] = 16'h2003;
        mem[16'h3003] = 16'h3004;
        mem[16'h3004] = 16'h8001;
        mem[16'h3005] = 16'h6003;
        mem[16'h3006] = 16'hFFFF;
        mem[16'h4000] = 16'h8ABC;
        mem[16'h4001] = 16'h6001;
        mem[16'h4002] = 16'hFFFF;
        mem[16'hFFFE] = 16'h2005;
        mem[16'hFFFF] = 16'h3007;
        mem[16'h0000] = 16'hFFFF;
        mem[16'h2000] = 16'h0001;
        mem[16'h2001] = 16'hFFFF;
        mem[16'h5000] = 16'h8001;
        mem[16'h5001] = 16'h6002;
        mem[16'h5002] = 16'hFFFF;

        // reset values
        reset_i = 1'b1;
        repeat (3) tick();
        reset_i = 1'b0;
        chk("rst_sel", vram_sel_o, 0);
        chk("rst_addr", vram_addr_o, 0);
        chk("rst_cmd", cmd_o, 0);
        chk("rst_valid", cmd_valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_count", count_o, 0);

        // basic list, immediate ack
        start_list(16'h1000);
        wait_done(60, "t1");
        check_basic_list("t1");
        chk("t1_sel_latency", sel_rise.size() > 0 ? sel_rise[0] - c0 : -1, 1);
        if (strobe_cyc.size() == 3) begin
            chk("t1_first_strobe", strobe_cyc[0] - c0, 3);
            chk("t1_gap01", strobe_cyc[1] - strobe_cyc[0], 3);
            chk("t1_gap12", strobe_cyc[2] - strobe_cyc[1], 3);
        end
        chk("t1_done_cycle", done_cyc - c0, 11);
        chk("t1_last_fetch", hs_addr.size() == 4 ? hs_addr[3] : 16'h0, 16'h1003);
        chk("t1_cmd_hold", cmd_o, 16'h605A);

        // execute with renderer busy for 40 cycles
        rndr_resp = 1'b1;
        start_list(16'h3000);
        wait_done(200, "t2");
        chk("t2_strobes", strobe_cyc.size(), 6);
        if (strobe_cyc.size() == 6) begin
            s = strobe_cyc[4];
            chk("t2_resume", next_sel_after(s) - s, 43);
            chk("t2_after_busy", next_sel_after(s), busy_end + 2);
        end

        // execute of an unknown primitive: renderer never starts
        rndr_resp = 1'b0;
        start_list(16'h4000);
        wait_done(80, "t3");
        chk("t3_strobes", strobe_cyc.size(), 2);
        if (strobe_cyc.size() == 2) begin
            s = strobe_cyc[0];
            chk("t3_timeout_resume", next_sel_after(s) - s, 9);
        end
        rndr_resp = 1'b1;

        // address wrap
        start_list(16'hFFFE);
        wait_done(60, "t4");
        chk("t4_fetches", hs_addr.size(), 3);
        if (hs_addr.size() == 3) begin
            chk("t4_a0", hs_addr[0], 16'hFFFE);
            chk("t4_a1", hs_addr[1], 16'hFFFF);
            chk("t4_a2", hs_addr[2], 16'h0000);
        end
        chk("t4_count_lit", count_o, 2);

        // abort during a withheld request
        ack_en = 1'b0;
        start_list(16'h2000);
        repeat (3) tick();
        chk("t5_sel_pending", vram_sel_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t5_sel_dropped", vram_sel_o, 0);
        chk("t5_idle", busy_o, 0);
        repeat (3) tick();
        chk("t5_no_done", done_cnt, 0);
        ack_en = 1'b1;
        start_list(16'h1000);
        wait_done(60, "t5b");
        check_basic_list("t5b");

        // arbiter stalls each request for 5 cycles
        ack_delay = 5;
        start_list(16'h1000);
        wait_done(200, "t6");
        check_basic_list("t6");
        chk("t6_first_strobe", strobe_cyc.size() > 0 ? strobe_cyc[0] - c0 : -1, 8);
        ack_delay = 0;

        // reset while waiting for the renderer to finish
        start_list(16'h5000);
        for (int i = 0; i < 50 && strobe_cyc.size() == 0; i++) tick();
        if (strobe_cyc.size() == 0) fail("t7_no_strobe");
        repeat (10) tick();
        chk("t7_in_wait", busy_o, 1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("t7_sel", vram_sel_o, 0);
        chk("t7_addr", vram_addr_o, 0);
        chk("t7_cmd", cmd_o, 0);
        chk("t7_valid", cmd_valid_o, 0);
        chk("t7_busy", busy_o, 0);
        chk("t7_done", done_o, 0);
        chk("t7_count", count_o, 0);
        busy_end = -100;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prim_cmd_list.md
# prim_cmd_list

Command-list fetcher that drives the primitive renderer's command port. It reads a list of 16-bit renderer command words from VRAM and presents them one per cycle on `cmd_o`/`cmd_valid_o`. After every execute command it stalls until the renderer has started and finished drawing. It sits between the VRAM arbiter (read client) and `prim_renderer` (command initiator), so the CPU can queue whole primitive lists instead of writing commands one by one.

## Interface
Parameters:
- `TIMEOUT_W`, 3: width of the start-wait counter; an execute is treated as a no-op if `busy_i` does not rise within 2^TIMEOUT_W cycles.

Ports:
- `clk`  in  1  system clock
- `reset_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  pulse: begin fetching at `list_addr_i`; ignored while `busy_o`=1
- `abort_i`  in  1  pulse: stop list immediately
- `list_addr_i`  in  16  VRAM word address of the first command
- `vram_sel_o`  out  1  VRAM read request, held until acknowledged
- `vram_addr_o`  out  16  VRAM read address
- `vram_ack_i`  in  1  arbiter grant; request accepted this cycle
- `vram_data_i`  in  16  read data, valid the cycle after `vram_ack_i`
- `cmd_o`  out  16  command word to renderer (`[15:12]` opcode, `[11:0]` payload)
- `cmd_valid_o`  out  1  one-cycle command strobe
- `rndr_busy_i`  in  1  renderer `busy_o`
- `busy_o`  out  1  list in progress
- `done_o`  out  1  one-cycle pulse when the terminator is reached
- `count_o`  out  16  number of commands issued in the current or last list

## Operation
- States: IDLE, REQ, DATA, ISSUE, WAIT_START, WAIT_DONE.
- IDLE, `start_i`=1: latch `list_addr_i` into the address pointer, clear `count_o`, go to REQ.
- REQ: `vram_sel_o`=1 with `vram_addr_o` equal to the pointer. On `vram_ack_i`=1, increment the pointer and go to DATA.
- DATA: capture `vram_data_i`.
  - If the word equals `xv::PR_LIST_END` (16'hFFFF), pulse `done_o` and go to IDLE. The terminator is not issued and not counted.
  - Otherwise go to ISSUE.
- ISSUE: `cmd_valid_o`=1 for exactly one cycle and `count_o`+1.
  - If opcode is `xv::PR_EXECUTE`, load the timeout counter and go to WAIT_START.
  - Otherwise go to REQ.
- WAIT_START: stay until `rndr_busy_i`=1 (then go to WAIT_DONE) or the timeout expires (then go to REQ).
- WAIT_DONE: stay while `rndr_busy_i`=1; go to REQ on the first cycle it is 0.
- Pointer arithmetic is 16-bit and wraps from 0xFFFF to 0x0000. `count_o` also wraps at 16 bits. There is no length limit; only the terminator or `abort_i` ends a list.
- `abort_i` in any non-IDLE state goes to IDLE next cycle:
  - `vram_sel_o` and `cmd_valid_o` drop to 0 and no `done_o` pulse is produced.
  - A pending ack is discarded.
  - An in-flight renderer draw is not stopped.
- If `abort_i` and `start_i` are asserted together in IDLE, start wins. In any other state both are handled by the abort rule.
- `busy_o` = (state != IDLE).

## Timing
- Reset values: state IDLE; `vram_sel_o`, `cmd_valid_o`, `busy_o`, `done_o` = 0; `vram_addr_o`, `cmd_o`, `count_o` = 0.
- `start_i` at cycle 0 gives `vram_sel_o`=1 at cycle 1.
- `vram_ack_i` at cycle k gives data captured at k+1 and `cmd_valid_o` at k+2. The next `vram_sel_o` is at k+3.
- With zero-wait ack, non-execute throughput is 1 command per 3 cycles.
- `cmd_o` holds its value after the strobe until the next ISSUE.
- The renderer raises busy 2 cycles after the strobe, which is why WAIT_START exists. The default 8-cycle timeout covers this latency.
- Done/`busy_o` relation: `done_o` is asserted in the same cycle `busy_o` is still 1; `busy_o` goes to 0 the next cycle.

## Structure
- Add to `xosera_pkg.sv` (package `xv`): `PR_LIST_END` = 16'hFFFF, and a state enum typedef `prim_list_st_t`.
- Reuse existing `xv::PR_EXECUTE` and the `xv::PR_*` coordinate opcodes.
- Single module, no sub-modules.
- The top level instantiates it and ties `cmd_o`, `cmd_valid_o` and `rndr_busy_i` to `prim_renderer`. The VRAM arbiter gives it read priority below the renderer write port.

## Test plan
- List at 0x1000: COORDX0=10, COORDY0=20, COLOR=0x5A, FFFF; ack every request immediately.
  - Required: 3 strobes with exactly those words, 3 cycles apart.
  - Required: `done_o` pulse, `count_o`=3, no word issued from 0x1003.
- EXECUTE(line) in the list; model `rndr_busy_i` high from strobe+2 for 40 cycles.
  - Required: the next `vram_sel_o` appears only on the cycle after busy falls.
- EXECUTE with an unknown primitive and `rndr_busy_i` held 0.
  - Required: fetch resumes 8 cycles after WAIT_START entry.
- List starting at 0xFFFE containing 2 commands then FFFF at 0x0000.
  - Required: `vram_addr_o` sequence 0xFFFE, 0xFFFF, 0x0000; `count_o`=2.
- `abort_i` during REQ with ack withheld.
  - Required: IDLE next cycle, `vram_sel_o`=0, no `done_o`.
  - Required: a new `start_i` then runs normally.
- Arbiter stalls ack 5 cycles per request.
  - Required: `vram_sel_o` and `vram_addr_o` stay stable through the stall.
  - Required: commands issue in the same order and with the same values as with immediate ack.
- `reset_i` asserted in WAIT_DONE.
  - Required: every output takes its reset value on the next cycle.
